// File: rtl/mem_access.sv
// MEM-stage data-memory access unit: load/store to req/ready handshake, store lane steering, load extension.
// Optional `MEM_BYPASS_EN: zero-wait completion in IDLE when dmem_ready arrives in the request cycle.
module mem_access #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead_in,
    input  logic                  MemWrite_in,
    input  logic [2:0]            funct3_in,
    input  logic [ADDR_WIDTH-1:0] ALU_result_in,
    input  logic [DATA_WIDTH-1:0] rs2_data_in,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ready,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_stall_out,
    output logic                  misaligned_out
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] data_q;

    logic                  access;
    logic                  is_store;
    logic                  misaligned;
    logic                  idle_issue;
    logic                  req_int;
    logic                  bypass_hit;
    logic [1:0]            off;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_fmt;
    logic [DATA_WIDTH-1:0] fmt_data;
    logic [DATA_WIDTH-1:0] wdata_lane;
    logic [3:0]            be_lane;

    always_comb begin
        access   = MemRead_in | MemWrite_in;
        // Both strobes high is decoded as a load.
        is_store = MemWrite_in & ~MemRead_in;
        off      = ALU_result_in[1:0];

        case (funct3_in[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            default: misaligned = |off;
        endcase

        byte_sel = dmem_rdata[{off, 3'b000} +: 8];
        half_sel = dmem_rdata[{off[1], 4'b0000} +: 16];
        case (funct3_in)
            3'b000:  load_fmt = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_fmt = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  load_fmt = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b101:  load_fmt = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_fmt = dmem_rdata;
        endcase
        fmt_data = is_store ? '0 : load_fmt;

        case (funct3_in[1:0])
            2'b00: begin
                wdata_lane = {4{rs2_data_in[7:0]}};
                be_lane    = 4'b0001 << off;
            end
            2'b01: begin
                wdata_lane = {2{rs2_data_in[15:0]}};
                be_lane    = off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_lane = rs2_data_in;
                be_lane    = 4'b1111;
            end
        endcase

        idle_issue = (state == IDLE) & access & ~misaligned;
        req_int    = idle_issue | (state == WAIT);
`ifdef MEM_BYPASS_EN
        bypass_hit = idle_issue & dmem_ready;
`else
        bypass_hit = 1'b0;
`endif
    end

    // Outputs are forced low while rst is high so an abandoned request drops immediately.
    always_comb begin
        dmem_req       = ~rst & req_int;
        dmem_we        = dmem_req & is_store;
        dmem_addr      = dmem_req ? {ALU_result_in[ADDR_WIDTH-1:2], 2'b00} : '0;
        dmem_wdata     = dmem_we ? wdata_lane : '0;
        dmem_be        = dmem_we ? be_lane : '0;
        mem_stall_out  = dmem_req & ~bypass_hit;
        misaligned_out = ~rst & (state == IDLE) & access & misaligned;
        if (rst)
            mem_data_out = '0;
        else if (state == DONE)
            mem_data_out = data_q;
        else if (bypass_hit)
            mem_data_out = fmt_data;
        else
            mem_data_out = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_issue && !bypass_hit) begin
                        if (dmem_ready) begin
                            data_q <= fmt_data;
                            state  <= DONE;
                        end else begin
                            state  <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ready) begin
                        data_q <= fmt_data;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: random loads/stores against a byte-level reference memory.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_in, MemWrite_in;
    logic [2:0]  funct3_in;
    logic [31:0] ALU_result_in, rs2_data_in;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, mem_data_out;
    logic [3:0]  dmem_be;
    logic        mem_stall_out, misaligned_out;

    always #5 clk = ~clk;

    mem_access #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .funct3_in(funct3_in),
        .ALU_result_in(ALU_result_in), .rs2_data_in(rs2_data_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .mem_data_out(mem_data_out), .mem_stall_out(mem_stall_out),
        .misaligned_out(misaligned_out)
    );

    typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} req_t;
    typedef struct {logic mis; logic [31:0] data;} rsp_t;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    int          nq[$];
    logic [31:0] mem_arr [256];
    logic [31:0] ref_mem [256];
    int          force_wait = -1;
    bit          busy = 1'b0;
    int          cnt = 0;
    int          stall_cnt = 0;
    int          total_stall = 0;
    int unsigned passed = 0, total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ld_val(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [31:0] addr);
        int unsigned off = addr % 4;
        logic [31:0] v;
        case (f3)
            3'b000: begin v = (word >> (8 * off)) & 32'hFF;   if (v >= 128)   v = v + 32'hFFFFFF00; end
            3'b001: begin v = (word >> (8 * off)) & 32'hFFFF; if (v >= 32768) v = v + 32'hFFFF0000; end
            3'b100: v = (word >> (8 * off)) & 32'hFF;
            3'b101: v = (word >> (8 * off)) & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
        int unsigned size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        int unsigned base = addr % 4;
        int unsigned idx  = (addr / 4) % 256;
        rsp_t r;
        req_t q;
        r.mis  = (addr % size) != 0;
        r.data = '0;
        if (!r.mis) begin
            q.we = !rd;
            q.addr = addr & ~32'd3;
            q.be = '0;
            q.wdata = '0;
            if (rd) begin
                r.data = ld_val(ref_mem[idx], f3, addr);
            end else begin
                for (int j = 0; j < 4; j++) q.wdata[8*j +: 8] = data[8*(j % size) +: 8];
                for (int unsigned i = 0; i < size; i++) begin
                    q.be[base + i] = 1'b1;
                    ref_mem[idx][8*(base + i) +: 8] = data[8*i +: 8];
                end
            end
            req_q.push_back(q);
        end
        rsp_q.push_back(r);
        MemRead_in = rd; MemWrite_in = wr; funct3_in = f3;
        ALU_result_in = addr; rs2_data_in = data;
    endtask

    // Holds the instruction (as the frozen EX/MEM would) until a cycle ends without stall.
    task automatic wait_done();
        int budget = 20;
        logic s;
        forever begin
            @(negedge clk); s = mem_stall_out;
            @(posedge clk); #1;
            if (!s) break;
            budget--;
            if (budget == 0) begin
                total++;
                $display("FAIL stall_timeout: stall still %b after 20 cycles, required 0", s);
                break;
            end
        end
    endtask

    task automatic go_idle(input int cycles);
        MemRead_in = 1'b0; MemWrite_in = 1'b0;
        funct3_in = 3'($urandom); ALU_result_in = $urandom; rs2_data_in = $urandom;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Memory responder: random wait states, byte-enable writes, garbage rdata when not ready.
    req_t cur;
    req_t e;
    initial begin
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                busy = 1'b0;
                dmem_ready = 1'b0;
            end else begin
                dmem_ready = 1'b0;
                dmem_rdata = $urandom;
                if (dmem_req) begin
                    if (!busy) begin
                        busy = 1'b1;
                        if (req_q.size() == 0) begin
                            total++;
                            $display("FAIL extra_req: got request addr %h, required none", dmem_addr);
                        end else begin
                            e = req_q.pop_front();
                            check("req_we", dmem_we, e.we);
                            check("req_addr", dmem_addr, e.addr);
                            check("req_be", dmem_be, e.be);
                            if (e.we) check("req_wdata", dmem_wdata, e.wdata);
                        end
                        cur.we = dmem_we; cur.addr = dmem_addr; cur.be = dmem_be; cur.wdata = dmem_wdata;
                        cnt = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
                        nq.push_back(cnt);
                    end else begin
                        check("hold_addr", dmem_addr, cur.addr);
                        check("hold_ctl", {dmem_we, dmem_be}, {cur.we, cur.be});
                        check("hold_wdata", dmem_wdata, cur.wdata);
                    end
                    if (cnt == 0) begin
                        dmem_ready = 1'b1;
                        dmem_rdata = mem_arr[dmem_addr[9:2]];
                        if (dmem_we)
                            for (int j = 0; j < 4; j++)
                                if (dmem_be[j]) mem_arr[dmem_addr[9:2]][8*j +: 8] = dmem_wdata[8*j +: 8];
                        busy = 1'b0;
                    end else begin
                        cnt--;
                    end
                end else begin
                    if (busy) begin
                        total++;
                        $display("FAIL req_dropped: got req 0 mid-transaction, required 1");
                        busy = 1'b0;
                    end
                    dmem_ready = ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    // Monitor: a cycle with an access and no stall retires the instruction.
    rsp_t r_m;
    int   n_m, exp_m;
    always @(negedge clk) begin
        if (rst) begin
            stall_cnt = 0;
        end else if (MemRead_in | MemWrite_in) begin
            if (mem_stall_out) begin
                stall_cnt++;
                total_stall++;
            end else begin
                if (rsp_q.size() == 0) begin
                    total++;
                    $display("FAIL extra_completion: got retire at %h, required none", ALU_result_in);
                end else begin
                    r_m = rsp_q.pop_front();
                    check("mem_data", mem_data_out, r_m.data);
                    check("misaligned", misaligned_out, r_m.mis);
                    if (r_m.mis) begin
                        check("mis_req", dmem_req, 0);
                        check("mis_stall_cycles", stall_cnt, 0);
                    end else if (nq.size() == 0) begin
                        total++;
                        $display("FAIL missing_req: got retire with no request, required one request");
                    end else begin
                        n_m = nq.pop_front();
`ifdef MEM_BYPASS_EN
                        exp_m = (n_m == 0) ? 0 : n_m + 1;
`else
                        exp_m = n_m + 1;
`endif
                        check("stall_cycles", stall_cnt, exp_m);
                    end
                end
                stall_cnt = 0;
            end
        end else begin
            check("idle_req", {dmem_req, mem_stall_out, misaligned_out}, 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not end, required $finish");
        $fatal(1);
    end

    int base_stall;
    req_t rq;
    initial begin
        rst = 1'b1;
        MemRead_in = 1'b1; MemWrite_in = 1'b0; funct3_in = 3'b010;
        ALU_result_in = 32'h100; rs2_data_in = '0;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[64] = 32'hDEADBEEF;
        ref_mem[64] = 32'hDEADBEEF;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req", dmem_req, 0);
        check("rst_stall", mem_stall_out, 0);
        check("rst_data", mem_data_out, 0);
        check("rst_misaligned", misaligned_out, 0);
        check("rst_bus", {dmem_we, dmem_be, dmem_addr, dmem_wdata}, 0);
        MemRead_in = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        force_wait = 2;
        issue(1, 0, 3'b010, 32'h100, 0);            wait_done();
        force_wait = -1;
        issue(0, 1, 3'b010, 32'h100, 32'h80FF1234); wait_done();
        issue(1, 0, 3'b000, 32'h103, 0);            wait_done();
        issue(1, 0, 3'b100, 32'h103, 0);            wait_done();
        issue(1, 0, 3'b001, 32'h102, 0);            wait_done();
        issue(0, 1, 3'b000, 32'h201, 32'h000000AB); wait_done();
        issue(0, 1, 3'b001, 32'h202, 32'h1234CDEF); wait_done();
        issue(1, 0, 3'b010, 32'h200, 0);            wait_done();
        issue(1, 0, 3'b010, 32'h102, 0);            wait_done();
        issue(0, 1, 3'b001, 32'h101, 32'h55);       wait_done();
        issue(1, 1, 3'b000, 32'h102, 32'hFFFFFFFF); wait_done();
        go_idle(2);

        // Reset pulse while the access sits in WAIT.
        force_wait = 3;
        issue(1, 0, 3'b010, 32'h100, 0);
        @(posedge clk); #3;
        check("wait_req", {dmem_req, mem_stall_out}, 2'b11);
        rst = 1'b1;
        #1;
        check("midrst_req", dmem_req, 0);
        check("midrst_stall", mem_stall_out, 0);
        check("midrst_data", mem_data_out, 0);
        busy = 1'b0;
        dmem_ready = 1'b0;
        nq.delete();
        rq.we = 1'b0; rq.addr = 32'h100; rq.be = '0; rq.wdata = '0;
        req_q.push_back(rq);
        force_wait = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_done();

        // Four back-to-back loads against a zero-wait memory.
        force_wait = 0;
        base_stall = total_stall;
        for (int i = 0; i < 4; i++) begin
            issue(1, 0, 3'b010, 32'h100 + 4 * i, 0);
            wait_done();
        end
`ifdef MEM_BYPASS_EN
        check("burst_stall_total", total_stall - base_stall, 0);
`else
        check("burst_stall_total", total_stall - base_stall, 4);
`endif
        force_wait = -1;

        for (int i = 0; i < 200; i++) begin
            int unsigned op = $urandom_range(0, 9);
            logic [2:0] f3;
            logic [31:0] a = 32'($urandom_range(0, 1023));
            if (op <= 5 || op == 9) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
                issue(1, (op == 9), f3, a, $urandom);
            end else begin
                f3 = 3'($urandom_range(0, 2));
                issue(0, 1, f3, a, $urandom);
            end
            wait_done();
            if ($urandom_range(0, 3) == 0) go_idle($urandom_range(1, 2));
        end
        go_idle(3);

        check("leftover_rsp", rsp_q.size(), 0);
        check("leftover_req", req_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

MEM-stage data-memory access unit between the EX/MEM pipeline register and the MEM/WB register. It turns load/store control from EX/MEM into a req/ready transaction on a variable-latency data memory. It byte-lanes store data and sign/zero-extends load data. It drives `mem_data_out` into MEM/WB `mem_data_in`, and asserts `mem_stall_out` so the hazard unit freezes PC, IF/ID, ID/EX and EX/MEM and bubbles MEM/WB (RegWrite/MemtoReg forced 0) while an access is outstanding.

## Interface
- `DATA_WIDTH`, 32, data/register width (fixed to `REG_DATA_WIDTH`; only 32 supported)
- `ADDR_WIDTH`, 32, byte address width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `MemRead_in`  in  1  load in MEM (from EX/MEM)
- `MemWrite_in`  in  1  store in MEM (from EX/MEM)
- `funct3_in`  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `ALU_result_in`  in  ADDR_WIDTH  byte address (from EX/MEM)
- `rs2_data_in`  in  DATA_WIDTH  store data (from EX/MEM)
- `dmem_req`  out  1  request valid
- `dmem_we`  out  1  1 = write
- `dmem_addr`  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
- `dmem_wdata`  out  DATA_WIDTH  lane-replicated store data
- `dmem_be`  out  4  byte enables (0000 on reads)
- `dmem_rdata`  in  DATA_WIDTH  read word, valid when `dmem_ready`
- `dmem_ready`  in  1  transaction complete this cycle
- `mem_data_out`  out  DATA_WIDTH  formatted load data to MEM/WB
- `mem_stall_out`  out  1  freeze upstream, bubble MEM/WB
- `misaligned_out`  out  1  misaligned access detected this cycle (one pulse per instruction)

## Operation
- Access = `MemRead_in | MemWrite_in`. Both high (never decoded) is treated as a load, `dmem_we`=0.
- Misaligned: W with addr[1:0]≠0; H/HU with addr[0]≠0. Request suppressed, `misaligned_out`=1, `mem_data_out`=0, no stall, state stays IDLE.
- Store lanes: SB wdata={4{rs2[7:0]}}, be=0001<<addr[1:0]; SH wdata={2{rs2[15:0]}}, be=0011 (addr[1]=0) / 1100; SW be=1111.
- Load format: select byte/half by addr[1:0]. B/H sign-extend, BU/HU zero-extend, W pass-through. Stores produce `mem_data_out`=0.
- FSM, 3 states:
  - IDLE: aligned access → `dmem_req`=1, `mem_stall_out`=1. On `dmem_ready`, latch formatted data into `data_q` and go to DONE; otherwise go to WAIT.
  - WAIT: hold `dmem_req`=1 with identical addr/we/wdata/be (EX/MEM frozen), `mem_stall_out`=1. On `dmem_ready`, latch and go to DONE.
  - DONE: `dmem_req`=0, `mem_stall_out`=0, `mem_data_out`=`data_q`. Go to IDLE unconditionally; no reissue of the same instruction.
- `dmem_ready` outside a request is ignored.

## Timing
- Reset (async): state←IDLE, `data_q`←0. While `rst`=1, every output is 0.
- Reset mid-access: request is dropped immediately. The memory tolerates an abandoned request, and a write may or may not have completed.
- Registered path: memory with N wait cycles (ready N cycles after req first rises) → `mem_stall_out` high N+1 cycles. MEM/WB captures data at the end of DONE.
- `mem_stall_out` depends only on state, access and misalignment, never on `dmem_ready` (unless bypass is enabled).
- Back-to-back accesses: a DONE→IDLE transition with a new access issues a request in the first IDLE cycle.

## Configuration
- `MEM_BYPASS_EN` defined: in IDLE, `dmem_ready` asserted in the request cycle completes with zero stall. `mem_stall_out`=0 and `mem_data_out`=formatted `dmem_rdata` combinationally, and the state stays IDLE. This creates a combinational ready→stall path.
- Undefined: every access takes the registered IDLE→DONE path, with a minimum 1 stall cycle.

## Test plan
- LW addr 0x100, memory returns 0xDEADBEEF after 2 wait cycles → stall high 3 cycles, `mem_data_out`=0xDEADBEEF in DONE, one req per load.
- LB/LBU addr 0x103 with rdata 0x80FF1234 → LB 0xFFFFFF80, LBU 0x00000080. LH addr 0x102 → 0xFFFF80FF.
- SB addr 0x201 data 0x000000AB → wdata 0xABABABAB, be 0010, we=1. SH addr 0x202 → be 1100.
- LW addr 0x102 → no req, `misaligned_out`=1, stall 0, `mem_data_out`=0.
- `rst` pulse while in WAIT → req/stall drop the same cycle, state IDLE; the next load completes normally.
- With `MEM_BYPASS_EN` and zero-wait memory, 4 consecutive loads → `mem_stall_out` never high. Without it → 4 stall cycles total.
